// File: rtl/imem_boot_ctrl.sv
// Boot and run-control sequencer for the Octa16 core: streams a program into
// instruction memory under core reset, then gates the core with run/halt/step.
module imem_boot_ctrl #(
    parameter int ADDR_W   = 8,
    parameter bit AUTO_RUN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_last,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_rst,
    output logic              core_en,
    output logic [1:0]        state,
    output logic              err,
    output logic [15:0]       cyc_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t            curState;
    state_t            nxtState;
    logic [ADDR_W-1:0] addrQ;
    logic [ADDR_W-1:0] lastQ;
    logic              byteAcc;
    logic              lastByte;
    logic              loadAcc;
    logic              stepGo;

    assign byteAcc  = (curState == LOAD) && s_valid;
    assign lastByte = byteAcc && (addrQ == lastQ);
    assign loadAcc  = load_start && (curState != LOAD);
    // A step only fires when no higher-priority request is present this cycle.
    assign stepGo   = (curState == HALT) && step_req && !load_start && !halt_req && !run_req;
    assign state    = curState;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curState <= IDLE;
        end else begin
            curState <= nxtState;
        end
    end

    always_comb begin
        nxtState = curState;
        case (curState)
            IDLE: begin
                if (load_start)                nxtState = LOAD;
                else if (!halt_req && run_req) nxtState = RUN;
            end
            LOAD: begin
                if (lastByte) nxtState = AUTO_RUN ? RUN : HALT;
            end
            RUN: begin
                if (load_start)    nxtState = LOAD;
                else if (halt_req) nxtState = HALT;
            end
            HALT: begin
                if (load_start)                nxtState = LOAD;
                else if (!halt_req && run_req) nxtState = RUN;
            end
            default: nxtState = IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        if (curState == LOAD) begin
            mem_we    = s_valid;
            mem_addr  = addrQ;
            mem_wdata = s_data;
        end
    end

    // Control outputs are registered from the next state so they change on the same edge as state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addrQ    <= '0;
            lastQ    <= '0;
            core_rst <= 1'b1;
            core_en  <= 1'b0;
            s_ready  <= 1'b0;
            err      <= 1'b0;
            cyc_cnt  <= 16'h0000;
        end else begin
            if (loadAcc) begin
                addrQ <= '0;
                lastQ <= load_last;
            end else if (byteAcc) begin
                addrQ <= lastByte ? '0 : addrQ + ADDR_W'(1);
            end
            core_rst <= (nxtState == IDLE) || (nxtState == LOAD);
            core_en  <= (nxtState == RUN) || stepGo;
            s_ready  <= (nxtState == LOAD);
            err      <= load_start && (curState == LOAD);
            if (loadAcc) begin
                cyc_cnt <= 16'h0000;
            end else if (core_en && (cyc_cnt != 16'hFFFF)) begin
                cyc_cnt <= cyc_cnt + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl; memory writes are checked by a scoreboard monitor.
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [7:0]  load_last;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        run_req;
    logic        halt_req;
    logic        step_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        core_rst;
    logic        core_en;
    logic [1:0]  state;
    logic        err;
    logic [15:0] cyc_cnt;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t expQ[$];

    always #5 clk = ~clk;

    imem_boot_ctrl #(.ADDR_W(8), .AUTO_RUN(1'b1)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_last(load_last),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .core_en(core_en), .state(state), .err(err), .cyc_cnt(cyc_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] addr, input logic [7:0] data, input bit gap);
        s_valid = 1'b1;
        s_data  = data;
        expQ.push_back('{addr, data});
        tick();
        s_valid = 1'b0;
        if (gap) begin
            s_data = 8'h33;
            tick();
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (s_valid !== 1'b1) begin
                nTests++;
                nFail++;
                $display("FAIL wr_no_valid: write at addr %0h with s_valid=%b", mem_addr, s_valid);
            end else if (expQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("FAIL wr_unexpected: addr %0h data %0h, none expected", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                chk("wr_addr", {24'h0, mem_addr}, {24'h0, e.addr});
                chk("wr_data", {24'h0, mem_wdata}, {24'h0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_start = 1'b0; load_last = 8'h00; s_valid = 1'b0; s_data = 8'h00;
        run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        tick(); tick();
        chk("rst_state", {30'h0, state}, 32'd0);
        chk("rst_core_rst", {31'h0, core_rst}, 32'd1);
        chk("rst_core_en", {31'h0, core_en}, 32'd0);
        chk("rst_s_ready", {31'h0, s_ready}, 32'd0);
        chk("rst_err", {31'h0, err}, 32'd0);
        chk("rst_cyc", {16'h0, cyc_cnt}, 32'd0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
        reset = 1'b0;
        tick();

        // Continuous load of 4 bytes.
        load_start = 1'b1; load_last = 8'd3;
        tick();
        load_start = 1'b0;
        chk("ld1_state", {30'h0, state}, 32'd1);
        chk("ld1_s_ready", {31'h0, s_ready}, 32'd1);
        chk("ld1_core_rst", {31'h0, core_rst}, 32'd1);
        for (int i = 0; i < 4; i++) feed(8'(i), 8'hA0 + 8'(i), 1'b0);
        chk("ld1_run_state", {30'h0, state}, 32'd2);
        chk("ld1_run_core_rst", {31'h0, core_rst}, 32'd0);
        chk("ld1_run_core_en", {31'h0, core_en}, 32'd1);
        chk("ld1_q_empty", expQ.size(), 32'd0);

        // Run 10 cycles, halt, then three spaced single steps.
        for (int i = 0; i < 9; i++) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halt_state", {30'h0, state}, 32'd3);
        chk("halt_core_en", {31'h0, core_en}, 32'd0);
        chk("halt_cyc", {16'h0, cyc_cnt}, 32'd10);
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            chk("step_en_hi", {31'h0, core_en}, 32'd1);
            tick();
            chk("step_en_lo", {31'h0, core_en}, 32'd0);
            chk("step_state", {30'h0, state}, 32'd3);
        end
        chk("step_cyc", {16'h0, cyc_cnt}, 32'd13);

        // Resume, then halt+run together in RUN: halt wins.
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("resume_state", {30'h0, state}, 32'd2);
        chk("resume_en", {31'h0, core_en}, 32'd1);
        halt_req = 1'b1; run_req = 1'b1;
        tick();
        halt_req = 1'b0; run_req = 1'b0;
        chk("hr_state", {30'h0, state}, 32'd3);
        chk("hr_en", {31'h0, core_en}, 32'd0);
        chk("hr_cyc", {16'h0, cyc_cnt}, 32'd14);

        // load_start + halt_req in HALT: load wins and clears the counter.
        load_start = 1'b1; halt_req = 1'b1; load_last = 8'd3;
        tick();
        load_start = 1'b0; halt_req = 1'b0;
        chk("lh_state", {30'h0, state}, 32'd1);
        chk("lh_cyc", {16'h0, cyc_cnt}, 32'd0);
        chk("lh_core_rst", {31'h0, core_rst}, 32'd1);
        for (int i = 0; i < 4; i++) feed(8'(i), 8'hB0 + 8'(i), 1'b1);
        chk("ld2_state", {30'h0, state}, 32'd2);
        chk("ld2_cyc", {16'h0, cyc_cnt}, 32'd1);
        chk("ld2_q_empty", expQ.size(), 32'd0);

        // load_start during LOAD flags err and leaves the load unchanged.
        load_start = 1'b1; load_last = 8'd4;
        tick();
        load_start = 1'b0;
        feed(8'd0, 8'hC0, 1'b0);
        feed(8'd1, 8'hC1, 1'b0);
        s_valid = 1'b1; s_data = 8'hC2;
        expQ.push_back('{8'd2, 8'hC2});
        load_start = 1'b1; load_last = 8'd1;
        tick();
        load_start = 1'b0; s_valid = 1'b0;
        chk("err_hi", {31'h0, err}, 32'd1);
        chk("err_state", {30'h0, state}, 32'd1);
        feed(8'd3, 8'hC3, 1'b0);
        chk("err_lo", {31'h0, err}, 32'd0);
        chk("err_still_load", {30'h0, state}, 32'd1);
        feed(8'd4, 8'hC4, 1'b0);
        chk("err_done_state", {30'h0, state}, 32'd2);
        chk("err_q_empty", expQ.size(), 32'd0);

        // Asynchronous reset mid-load after 2 of 5 bytes.
        load_start = 1'b1; load_last = 8'd4;
        tick();
        load_start = 1'b0;
        feed(8'd0, 8'hD0, 1'b0);
        feed(8'd1, 8'hD1, 1'b0);
        s_valid = 1'b1; s_data = 8'hD2;
        #2 reset = 1'b1;
        #1;
        chk("mr_state", {30'h0, state}, 32'd0);
        chk("mr_s_ready", {31'h0, s_ready}, 32'd0);
        chk("mr_core_rst", {31'h0, core_rst}, 32'd1);
        chk("mr_core_en", {31'h0, core_en}, 32'd0);
        chk("mr_mem_we", {31'h0, mem_we}, 32'd0);
        chk("mr_mem_addr", {24'h0, mem_addr}, 32'd0);
        chk("mr_mem_wdata", {24'h0, mem_wdata}, 32'd0);
        chk("mr_cyc", {16'h0, cyc_cnt}, 32'd0);
        tick();
        reset = 1'b0; s_valid = 1'b0;
        tick();

        // Full-memory load: 256 bytes, addresses 0..255.
        load_start = 1'b1; load_last = 8'd255;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 256; i++) feed(8'(i), 8'(i) ^ 8'h5A, 1'b0);
        chk("full_state", {30'h0, state}, 32'd2);
        chk("full_core_rst", {31'h0, core_rst}, 32'd0);
        chk("full_q_empty", expQ.size(), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot and run-control sequencer for the Octa16 core. It owns the instruction-memory external write port (`Ext_MemWrite`/`Ext_DataAdr`/`Ext_WriteData`). It loads a program from a byte stream, holds the core in reset while loading, and then releases it. After release it provides run, halt and single-step control by gating the core's clock-enable (PC and architectural-state update enable). It also counts executed cycles for the host.

## Interface

Parameters:
- ADDR_W, 8, instruction-memory address width.
- AUTO_RUN, 1, 1: enter RUN after a completed load; 0: enter HALT.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle request to begin a program load.
- load_last  in  ADDR_W  last address to write; sampled with load_start, so the load writes load_last+1 bytes.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_ready  out  1  stream byte accepted when s_valid & s_ready.
- run_req  in  1  start or resume execution.
- halt_req  in  1  stop execution.
- step_req  in  1  execute exactly one cycle while halted.
- mem_we  out  1  instruction-memory write strobe; drives Ext_MemWrite.
- mem_addr  out  ADDR_W  write address; drives Ext_DataAdr.
- mem_wdata  out  8  write data; drives Ext_WriteData.
- core_rst  out  1  core reset; holds PC and register file in reset.
- core_en  out  1  core update enable.
- state  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3.
- err  out  1  one-cycle pulse when load_start is received in LOAD.
- cyc_cnt  out  16  number of core_en-high cycles since the last load_start; saturates at 16'hFFFF.

## Operation

- States:
  - IDLE: core_rst=1, core_en=0, s_ready=0.
  - LOAD: core_rst=1, core_en=0, s_ready=1.
  - RUN: core_rst=0, core_en=1.
  - HALT: core_rst=0, core_en=0 except during a step cycle.
- Request priority in a single cycle: load_start > halt_req > run_req > step_req.
- IDLE:
  - load_start -> LOAD; addr_q=0, last_q=load_last, cyc_cnt=0.
  - run_req -> RUN. The core was held in reset, so PC starts at 0.
- LOAD:
  - mem_we = s_valid (combinational), mem_addr = addr_q, mem_wdata = s_data.
  - On each accepted byte, addr_q increments.
  - On accepting the byte at addr_q==last_q: go to RUN if AUTO_RUN=1, else HALT. addr_q returns to 0.
  - Cycles without s_valid stall the load indefinitely; there is no timeout.
  - halt_req, run_req and step_req are ignored.
  - load_start raises err for one cycle and is otherwise ignored; the load continues unchanged.
- RUN:
  - halt_req -> HALT.
  - load_start -> LOAD; core_rst reasserts on the next cycle.
  - run_req and step_req are ignored.
- HALT:
  - run_req -> RUN.
  - step_req: core_en=1 for exactly the following cycle, then 0; state stays HALT.
  - step_req received during that step cycle starts another step on the next cycle.
  - load_start -> LOAD.
- Outside LOAD: mem_we=0, mem_addr=0, mem_wdata=0.
- Address arithmetic is modulo 2^ADDR_W. load_last = 2^ADDR_W-1 writes the full memory; addr_q never wraps within one load.
- cyc_cnt increments on every cycle with core_en=1 and saturates at 16'hFFFF. It clears only on an accepted load_start.

## Timing

- Reset values: state=IDLE, core_rst=1, core_en=0, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, cyc_cnt=0; addr_q=0, last_q=0.
- Reset asserted mid-load or mid-run forces these values immediately; no partial-load recovery.
- State, core_rst, core_en, s_ready, err and cyc_cnt are registered.
- mem_we, mem_addr and mem_wdata are combinational from the registered state and the stream inputs. The write occurs in the same cycle as the handshake.
- load_start accepted at edge T: s_ready=1 and core_rst=1 from cycle T+1.
- Last byte accepted in cycle T: state=RUN, core_rst=0, core_en=1 from T+1. The first fetch from address 0 occurs in T+1.
- halt_req at T: core_en=0 from T+1.
- run_req at T: core_en=1 from T+1.
- step_req at T in HALT: core_en=1 during T+1 only.

## Test plan

- Reset, load_start with load_last=3, bytes A0,A1,A2,A3 with s_valid held high -> mem_we high for 4 cycles at addresses 0..3. state=RUN and core_rst=0 the cycle after A3.
- Same load with s_valid toggling every other cycle -> exactly 4 writes, addresses contiguous, no write in cycles with s_valid=0.
- RUN 10 cycles, halt_req, then step_req 3 times spaced 2 cycles apart -> cyc_cnt=13, core_en high in exactly 3 single-cycle pulses.
- halt_req and run_req asserted together in RUN -> HALT. load_start and halt_req asserted together in HALT -> LOAD with cyc_cnt=0.
- load_start during LOAD -> err pulses one cycle, last_q and addr_q unchanged, load completes with the original length.
- Assert reset mid-load after 2 of 5 bytes -> all outputs at reset values immediately, s_ready=0. A later load_last=255 writes 256 bytes, addresses 0..255 without wrap.
